addition_scheduler: RTL and testbench
=====================================

ADDITION_SCHEDULER -- requirements
Module: addition_scheduler

Interface
REQ-001 Parameter LEN_W, default 10, width of the stream-length and ones counters.
REQ-002 Parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-003 clkB  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a scaled-addition run; honoured only in IDLE.
REQ-006 abort  input  1  terminate a run in progress.
REQ-007 len  input  LEN_W  number of bitstream cycles to run.
REQ-008 Anummax, Bnummax  input  9 each  maxima of the two operand streams.
REQ-009 c  input  1  selected output bit returned from the adder mux.
REQ-010 d  output  1  select driven to the adder: 0 selects a, 1 selects b.
REQ-011 stream_en  output  1  high when the operand stream generators must emit a bit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a run completes.
REQ-014 ones  output  LEN_W  count of c==1 cycles in the last completed run.
REQ-015 newnummax  output  9  Anummax+Bnummax, truncated to 9 bits.
REQ-016 ovf  output  1  carry-out of the newnummax sum.

Function
REQ-017 FSM states are IDLE, LOAD, RUN and DONE.
REQ-018 IDLE->LOAD on start==1 && len!=0; start with len==0 is ignored.
REQ-019 LOAD lasts one cycle: latch len into remaining, clear the ones accumulator, register {ovf,newnummax} = Anummax+Bnummax; then go to RUN.
REQ-020 RUN: stream_en=1 and d=lfsr[0]; each edge adds c to the accumulator, decrements remaining and advances the LFSR.
REQ-021 RUN->DONE on the edge where remaining==1, i.e. after exactly len RUN cycles.
REQ-022 DONE lasts one cycle: done=1, ones = accumulator; then go to IDLE.
REQ-023 With start sampled at edge k, LOAD is cycle k+1, RUN spans cycles k+2..k+1+len, and done is high in cycle k+2+len.
REQ-024 Accumulator width is LEN_W and cannot overflow, since ones <= len <= 2^LEN_W-1.
REQ-025 LFSR is 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, and advances only in RUN.
REQ-026 The LFSR is not reseeded between runs.
REQ-027 d and stream_en are 0 outside RUN.
REQ-028 abort in RUN or LOAD forces IDLE next cycle: no done pulse, ones unchanged.
REQ-029 abort in IDLE or DONE has no effect.
REQ-030 abort and start asserted in the same IDLE cycle: start wins.
REQ-031 start outside IDLE is ignored and is not queued.
REQ-032 ones, newnummax and ovf hold their values until the next DONE or LOAD respectively.

Reset
REQ-033 reset asynchronously sets: state=IDLE, lfsr=SEED, remaining=0, accumulator=0, ones=0, newnummax=0, ovf=0, done=0, busy=0, d=0, stream_en=0.
REQ-034 reset mid-run discards the run: no done pulse after reset deasserts.

Structure
REQ-035 Shared package sc_pkg SHALL hold the FSM state enum, the LFSR tap mask constant and the default SEED.
REQ-036 The LFSR SHALL be a separate sub-module, sc_lfsr16, with ports clkB, reset, en, seed and q.

Verification
REQ-037 Stream a=b=1, len=100, start -> done at start+102, ones=100, d toggles during RUN.
REQ-038 Anummax=300, Bnummax=300 -> newnummax=88, ovf=1; Anummax=100, Bnummax=50 -> newnummax=150, ovf=0.
REQ-039 a=1, b=0, len=1000 -> ones equals the count of d==0 cycles, matched against a reference LFSR model from SEED.
REQ-040 abort at 5th RUN cycle with len=20 -> IDLE next cycle, no done, previous ones retained; a second start still runs normally.
REQ-041 start re-pulsed during RUN, and start with len=0 in IDLE -> both ignored, and busy/done timing is unchanged.
REQ-042 reset asserted mid-RUN -> all outputs match REQ-033 immediately, no done pulse follows, and lfsr restarts from SEED.

Source files
------------

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and constants for the scaled-addition scheduler
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sc_state_t;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/sc_lfsr16.sv
// rtl/sc_lfsr16.sv - 16-bit Fibonacci LFSR, advances only while en is high
module sc_lfsr16
    import sc_pkg::*;
(
    input  logic        clkB,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clkB or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/addition_scheduler.sv
// rtl/addition_scheduler.sv - schedules a stochastic scaled addition over len bitstream cycles
module addition_scheduler
    import sc_pkg::*;
#(
    parameter int          LEN_W = 10,
    parameter logic [15:0] SEED  = DEFAULT_SEED
) (
    input  logic             clkB,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic [8:0]       Anummax,
    input  logic [8:0]       Bnummax,
    input  logic             c,
    output logic             d,
    output logic             stream_en,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] ones,
    output logic [8:0]       newnummax,
    output logic             ovf
);

    // An all-zero seed would lock the LFSR, so fall back to the default
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    sc_state_t        state;
    sc_state_t        state_nx;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] acc;
    logic [LEN_W-1:0] acc_nx;
    logic [15:0]      lfsr_q;
    logic [9:0]       nummax_sum;
    logic             unused_lfsr;

    sc_lfsr16 u_lfsr (
        .clkB  (clkB),
        .reset (reset),
        .en    (state == RUN),
        .seed  (SEED_SAFE),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:1];
    assign nummax_sum  = {1'b0, Anummax} + {1'b0, Bnummax};
    assign acc_nx      = acc + {{(LEN_W-1){1'b0}}, c};

    always_ff @(posedge clkB or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        stream_en = 1'b0;
        d         = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (len != '0)) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = abort ? IDLE : RUN;
            end
            RUN: begin
                stream_en = 1'b1;
                d         = lfsr_q[0];
                if (abort) begin
                    state_nx = IDLE;
                end else if (remaining == LEN_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ones is published on the last RUN edge so it is already valid while done is high
    always_ff @(posedge clkB or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            acc       <= '0;
            ones      <= '0;
            newnummax <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    remaining        <= len;
                    acc              <= '0;
                    {ovf, newnummax} <= nummax_sum;
                end
                RUN: begin
                    if (!abort) begin
                        remaining <= remaining - LEN_W'(1);
                        acc       <= acc_nx;
                        if (remaining == LEN_W'(1)) begin
                            ones <= acc_nx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addition_scheduler.sv
// tb/tb_addition_scheduler.sv - directed self-checking bench for addition_scheduler
module tb_addition_scheduler;

    logic       clkB = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] len = '0;
    logic [8:0] Anummax = '0;
    logic [8:0] Bnummax = '0;
    logic       c;
    logic       d, stream_en, busy, done, ovf;
    logic [9:0] ones;
    logic [8:0] newnummax;
    logic       sa = 1'b0;
    logic       sb = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mlfsr = 16'hACE1;
    int lat, rcnt, mzeros, toggles, dmis, ones_at_done, prev_ones, cnt_w;

    addition_scheduler dut (
        .clkB      (clkB),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .Anummax   (Anummax),
        .Bnummax   (Bnummax),
        .c         (c),
        .d         (d),
        .stream_en (stream_en),
        .busy      (busy),
        .done      (done),
        .ones      (ones),
        .newnummax (newnummax),
        .ovf       (ovf)
    );

    assign c = d ? sb : sa;

    always #5 clkB = ~clkB;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] m);
        logic fb;
        fb = m[0] ^ m[2] ^ m[3] ^ m[5];
        return {fb, m[15:1]};
    endfunction

    task automatic run_op(input int l, input int abort_at, input int repulse_at, input int reset_at);
        int   cnt;
        logic prev;
        lat = 0; rcnt = 0; mzeros = 0; toggles = 0; dmis = 0; ones_at_done = -1;
        prev = 1'b0;
        @(negedge clkB);
        start = 1'b1;
        len   = l[9:0];
        @(negedge clkB);
        start = 1'b0;
        cnt   = 1;
        while (!done && cnt < 3000) begin
            @(negedge clkB);
            cnt++;
            start = 1'b0;
            if (stream_en) begin
                rcnt++;
                if (d !== mlfsr[0]) dmis++;
                if (mlfsr[0] == 1'b0) mzeros++;
                if (rcnt > 1 && d !== prev) toggles++;
                prev  = d;
                mlfsr = model_step(mlfsr);
                if (rcnt == repulse_at) start = 1'b1;
                if (rcnt == abort_at) begin
                    abort = 1'b1;
                    @(negedge clkB);
                    abort = 1'b0;
                    return;
                end
                if (rcnt == reset_at) begin
                    reset = 1'b1;
                    #1;
                    return;
                end
            end
        end
        lat          = cnt;
        ones_at_done = ones;
    endtask

    initial begin
        repeat (2) @(negedge clkB);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_stream_en", stream_en, 0);
        check("rst_ones", ones, 0);
        check("rst_newnummax", newnummax, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;

        // a=b=1, len=100, sum with carry out
        Anummax = 9'd300; Bnummax = 9'd300; sa = 1'b1; sb = 1'b1;
        run_op(100, 0, 0, 0);
        check("a_latency", lat, 102);
        check("a_run_cycles", rcnt, 100);
        check("a_ones", ones_at_done, 100);
        check("a_d_vs_model", dmis, 0);
        check("a_d_toggles", (toggles > 0), 1);
        check("a_newnummax", newnummax, 88);
        check("a_ovf", ovf, 1);
        @(negedge clkB);
        check("a_done_one_cycle", done, 0);
        check("a_busy_after", busy, 0);

        // a=1, b=0, len=1000: ones counts d==0 cycles
        Anummax = 9'd100; Bnummax = 9'd50; sa = 1'b1; sb = 1'b0;
        run_op(1000, 0, 0, 0);
        check("b_latency", lat, 1002);
        check("b_ones", ones_at_done, mzeros);
        check("b_d_vs_model", dmis, 0);
        check("b_newnummax", newnummax, 150);
        check("b_ovf", ovf, 0);
        prev_ones = mzeros;

        // abort on the 5th RUN cycle
        sa = 1'b1; sb = 1'b1;
        run_op(20, 5, 0, 0);
        check("c_abort_busy", busy, 0);
        check("c_abort_done", done, 0);
        check("c_abort_ones", ones, prev_ones);
        check("c_abort_d_vs_model", dmis, 0);
        cnt_w = 0;
        repeat (30) begin
            @(negedge clkB);
            cnt_w += int'(done) + int'(busy);
        end
        check("c_no_done_after_abort", cnt_w, 0);
        run_op(10, 0, 0, 0);
        check("c_rerun_latency", lat, 12);
        check("c_rerun_ones", ones_at_done, 10);
        check("c_rerun_d_vs_model", dmis, 0);

        // start re-pulsed mid-run is neither honoured nor queued
        run_op(30, 0, 3, 0);
        check("d_repulse_latency", lat, 32);
        check("d_repulse_ones", ones_at_done, 30);
        cnt_w = 0;
        repeat (4) begin
            @(negedge clkB);
            cnt_w += int'(busy);
        end
        check("d_not_queued", cnt_w, 0);

        // start with len=0 is ignored
        @(negedge clkB);
        start = 1'b1;
        len   = '0;
        @(negedge clkB);
        start = 1'b0;
        cnt_w = 0;
        repeat (4) begin
            cnt_w += int'(busy) + int'(done);
            @(negedge clkB);
        end
        check("e_len0_ignored", cnt_w, 0);

        // reset asserted mid-RUN
        run_op(50, 0, 0, 10);
        check("f_rst_busy", busy, 0);
        check("f_rst_done", done, 0);
        check("f_rst_d", d, 0);
        check("f_rst_stream_en", stream_en, 0);
        check("f_rst_ones", ones, 0);
        check("f_rst_newnummax", newnummax, 0);
        check("f_rst_ovf", ovf, 0);
        mlfsr = 16'hACE1;
        @(negedge clkB);
        reset = 1'b0;
        cnt_w = 0;
        repeat (60) begin
            @(negedge clkB);
            cnt_w += int'(done) + int'(busy);
        end
        check("f_no_done_after_reset", cnt_w, 0);
        sa = 1'b1; sb = 1'b0;
        run_op(16, 0, 0, 0);
        check("f_reseed_latency", lat, 18);
        check("f_reseed_d_vs_model", dmis, 0);
        check("f_reseed_ones", ones_at_done, mzeros);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
